i2s_tdm_rx: RTL and testbench

//  I2S/TDM slave receiver: samples externally driven bclk/lrck/sdin in the mclki domain and deserializes
//  MSB-first slot words onto a valid/ready stream. Pairs with the on-chip bclk/lrck divider as the capture
//  end of the same link (codec ADC path, or loopback of our own generated clocks).

---
 rtl/i2s_pkg.sv | 23 ++
 rtl/i2s_in_sync.sv | 34 +++
 rtl/i2s_tdm_rx.sv | 168 ++++++++++++++++
 tb/tb_i2s_tdm_rx.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/i2s_pkg.sv
// Shared constants, FSM state encoding and config check for the I2S/TDM receiver.
package i2s_pkg;

  localparam int unsigned MAX_WORD = 32;
  localparam int unsigned MAX_TDM  = 16;
  localparam int unsigned MIN_WW   = 16;
  localparam int unsigned MAX_WW   = 32;
  localparam int unsigned MIN_SLOT = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    DELAY = 2'd2,
    SHIFT = 2'd3
  } state_t;

  function automatic logic cfg_ok(input logic [5:0] ww, input logic [4:0] tdm,
                                  input int unsigned max_ww, input int unsigned max_tdm);
    return (32'(ww) >= MIN_WW) && (32'(ww) <= max_ww) &&
           (32'(tdm) >= MIN_SLOT) && (32'(tdm) <= max_tdm);
  endfunction

endpackage

// File: rtl/i2s_in_sync.sv
// Two-flop synchronizer for one async input; RISE_DET=1 outputs a one-cycle rise pulse instead of the level.
module i2s_in_sync #(
  parameter bit RISE_DET = 1'b0
) (
  input  logic mclki,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta, sync;

  always_ff @(posedge mclki or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      sync <= 1'b0;
    end else begin
      meta <= d;
      sync <= meta;
    end
  end

  if (RISE_DET) begin : g_rise
    logic sync_d;
    always_ff @(posedge mclki or negedge rst_n) begin
      if (!rst_n) sync_d <= 1'b0;
      else        sync_d <= sync;
    end
    assign q = sync & ~sync_d;
  end else begin : g_level
    assign q = sync;
  end

endmodule

// File: rtl/i2s_tdm_rx.sv
// I2S/TDM slave receiver: deserializes MSB-first slot words onto a valid/ready stream.
// Optional frame length status counter enabled by defining I2S_RX_STATUS_EN.
module i2s_tdm_rx #(
  parameter int unsigned MAX_WORD = i2s_pkg::MAX_WORD,
  parameter int unsigned MAX_TDM  = i2s_pkg::MAX_TDM
) (
  input  logic                        mclki,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic                        bclk,
  input  logic                        lrck,
  input  logic                        sdin,
  input  logic [5:0]                  word_width,
  input  logic [4:0]                  tdm_num,
  input  logic                        data_delay,
  output logic [MAX_WORD-1:0]         m_tdata,
  output logic [$clog2(MAX_TDM)-1:0]  m_tslot,
  output logic                        m_tlast,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic                        overflow,
  output logic                        frame_err,
  output logic [9:0]                  frame_bclks
);
  import i2s_pkg::*;

  localparam int unsigned SW = $clog2(MAX_TDM);

  logic bclk_rise, lrck_now, sd_now, lrck_s, fs;
  state_t state_q, state_d;
  logic [5:0] bit_q, bit_d, ww_q, ww_d;
  logic [4:0] slot_q, slot_d, tdm_q, tdm_d;
  logic [MAX_WORD-1:0] sh_q, sh_d, sh_in;
  logic done, err_set, last_bit, word_end;

  i2s_in_sync #(.RISE_DET(1'b1)) u_bclk (.mclki(mclki), .rst_n(rst_n), .d(bclk), .q(bclk_rise));
  i2s_in_sync #(.RISE_DET(1'b0)) u_lrck (.mclki(mclki), .rst_n(rst_n), .d(lrck), .q(lrck_now));
  i2s_in_sync #(.RISE_DET(1'b0)) u_sdin (.mclki(mclki), .rst_n(rst_n), .d(sdin), .q(sd_now));

  assign fs       = bclk_rise & lrck_now & ~lrck_s;
  assign sh_in    = (bit_q == '0) ? MAX_WORD'(sd_now) : {sh_q[MAX_WORD-2:0], sd_now};
  assign word_end = (bit_q == ww_q - 6'd1);
  assign last_bit = (state_q == SHIFT) && word_end && (slot_q == tdm_q - 5'd1);

  always_ff @(posedge mclki or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      slot_q  <= '0;
      sh_q    <= '0;
      ww_q    <= '0;
      tdm_q   <= '0;
      lrck_s  <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      slot_q  <= slot_d;
      sh_q    <= sh_d;
      ww_q    <= ww_d;
      tdm_q   <= tdm_d;
      if (bclk_rise) lrck_s <= lrck_now;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    slot_d  = slot_q;
    sh_d    = sh_q;
    ww_d    = ww_q;
    tdm_d   = tdm_q;
    done    = 1'b0;
    err_set = 1'b0;
    if (!enable) begin
      state_d = IDLE;
    end else if (state_q == IDLE) begin
      state_d = HUNT;
    end else if (bclk_rise) begin
      if (state_q == SHIFT) begin
        sh_d = sh_in;
        if (word_end) begin
          done   = 1'b1;
          bit_d  = '0;
          slot_d = slot_q + 5'd1;
          if (slot_q == tdm_q - 5'd1) state_d = HUNT;
        end else begin
          bit_d = bit_q + 6'd1;
        end
      end else if (state_q == DELAY) begin
        sh_d    = MAX_WORD'(sd_now);
        bit_d   = 6'd1;
        state_d = SHIFT;
      end
      if (fs) begin
        // A sync coinciding with the final LSB is the normal back-to-back I2S case, not an error.
        if ((state_q == SHIFT || state_q == DELAY) && !last_bit) begin
          err_set = 1'b1;
          done    = 1'b0;
        end
        ww_d   = word_width;
        tdm_d  = tdm_num;
        slot_d = '0;
        if (!cfg_ok(word_width, tdm_num, (MAX_WW < MAX_WORD) ? MAX_WW : MAX_WORD, MAX_TDM)) begin
          state_d = HUNT;
        end else if (data_delay) begin
          state_d = DELAY;
          bit_d   = '0;
        end else begin
          state_d = SHIFT;
          sh_d    = MAX_WORD'(sd_now);
          bit_d   = 6'd1;
        end
      end
    end
  end

  always_ff @(posedge mclki or negedge rst_n) begin
    if (!rst_n) begin
      m_tvalid  <= 1'b0;
      m_tdata   <= '0;
      m_tslot   <= '0;
      m_tlast   <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else if (!enable) begin
      m_tvalid  <= 1'b0;
      overflow  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (err_set) frame_err <= 1'b1;
      if (done) begin
        if (!m_tvalid || m_tready) begin
          m_tvalid <= 1'b1;
          m_tdata  <= sh_in;
          m_tslot  <= slot_q[SW-1:0];
          m_tlast  <= (slot_q == tdm_q - 5'd1);
        end else begin
          overflow <= 1'b1;
        end
      end else if (m_tready) begin
        m_tvalid <= 1'b0;
      end
    end
  end

`ifdef I2S_RX_STATUS_EN
  logic [9:0] fb_cnt, fb_q;

  always_ff @(posedge mclki or negedge rst_n) begin
    if (!rst_n) begin
      fb_cnt <= '0;
      fb_q   <= '0;
    end else if (bclk_rise) begin
      if (fs) begin
        fb_q   <= (fb_cnt == '1) ? '1 : fb_cnt + 10'd1;
        fb_cnt <= '0;
      end else if (fb_cnt != '1) begin
        fb_cnt <= fb_cnt + 10'd1;
      end
    end
  end

  assign frame_bclks = fb_q;
`else
  assign frame_bclks = '0;
`endif

endmodule

// File: tb/tb_i2s_tdm_rx.sv
// Scoreboard bench for i2s_tdm_rx: directed serial frames, expected beats queued, monitor pops on handshake.
module tb_i2s_tdm_rx;

  logic        mclki = 1'b0;
  logic        rst_n, enable, bclk, lrck, sdin, data_delay, m_tready;
  logic [5:0]  word_width;
  logic [4:0]  tdm_num;
  logic [31:0] m_tdata;
  logic [3:0]  m_tslot;
  logic        m_tlast, m_tvalid, overflow, frame_err;
  logic [9:0]  frame_bclks;

  typedef struct packed {
    logic [31:0] d;
    logic [3:0]  s;
    logic        l;
  } beat_t;

  beat_t       expq[$];
  logic [1:0]  bq[$];
  logic [31:0] words[16];
  logic        carry;
  int          checks   = 0;
  int          failures = 0;

  always #5 mclki = ~mclki;

  i2s_tdm_rx #(.MAX_WORD(32), .MAX_TDM(16)) dut (
    .mclki(mclki), .rst_n(rst_n), .enable(enable), .bclk(bclk), .lrck(lrck), .sdin(sdin),
    .word_width(word_width), .tdm_num(tdm_num), .data_delay(data_delay),
    .m_tdata(m_tdata), .m_tslot(m_tslot), .m_tlast(m_tlast), .m_tvalid(m_tvalid),
    .m_tready(m_tready), .overflow(overflow), .frame_err(frame_err), .frame_bclks(frame_bclks)
  );

  always @(negedge mclki) begin
    if (rst_n && m_tvalid && m_tready) begin
      checks++;
      if (expq.size() == 0) begin
        failures++;
        $display("FAIL beat_unexpected got data=%h slot=%0d last=%b required no beat",
                 m_tdata, m_tslot, m_tlast);
      end else begin
        beat_t e;
        e = expq.pop_front();
        if (m_tdata !== e.d || m_tslot !== e.s || m_tlast !== e.l) begin
          failures++;
          $display("FAIL beat got data=%h slot=%0d last=%b required data=%h slot=%0d last=%b",
                   m_tdata, m_tslot, m_tlast, e.d, e.s, e.l);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge mclki);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] d, input int s, input logic l);
    beat_t b;
    b.d = d;
    b.s = 4'(s);
    b.l = l;
    expq.push_back(b);
  endtask

  // Builds serial bits {lrck, sd}; i2s shifts data one bclk after the sync.
  task automatic append_frame(input int ww, input int tdm, input bit i2s, input int limit);
    int n;
    n = ww * tdm;
    for (int r = 0; r < limit; r++) begin
      int   k;
      logic sd;
      k = i2s ? r - 1 : r;
      if (k < 0) sd = carry;
      else       sd = words[k / ww][ww - 1 - (k % ww)];
      bq.push_back({logic'(r < n / 2), sd});
    end
    carry = (i2s && limit == n) ? words[tdm - 1][0] : 1'b0;
  endtask

  task automatic append_idle(input int n);
    for (int r = 0; r < n; r++) begin
      bq.push_back({1'b0, (r == 0) ? carry : 1'b0});
    end
    carry = 1'b0;
  endtask

  task automatic play(input int n);
    int cnt;
    cnt = 0;
    while (bq.size() != 0 && (n < 0 || cnt < n)) begin
      logic [1:0] b;
      b = bq.pop_front();
      @(posedge mclki); #1;
      bclk = 1'b0;
      lrck = b[1];
      sdin = b[0];
      cycles(4);
      bclk = 1'b1;
      cycles(4);
      cnt++;
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 400 && expq.size() != 0; i++) @(posedge mclki);
    cycles(2);
    chk(name, 32'(expq.size()), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; bclk = 1'b0; lrck = 1'b0; sdin = 1'b0;
    word_width = 6'd32; tdm_num = 5'd2; data_delay = 1'b1; m_tready = 1'b1;
    carry = 1'b0;
    cycles(5);
    @(negedge mclki);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_tslot", 32'(m_tslot), 32'd0);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_frame_bclks", 32'(frame_bclks), 32'd0);
    rst_n = 1'b1;
    cycles(2);
    enable = 1'b1;
    cycles(4);

    // I2S stereo, 32-bit words
    word_width = 6'd32; tdm_num = 5'd2; data_delay = 1'b1;
    words[0] = 32'hA5A5_0001; words[1] = 32'h5A5A_0002;
    push_exp(32'hA5A5_0001, 0, 1'b0);
    push_exp(32'h5A5A_0002, 1, 1'b1);
    append_idle(4); append_frame(32, 2, 1'b1, 64); append_idle(6);
    play(-1);
    drain("t1_drain");

    // Left-justified TDM8, 16-bit words
    word_width = 6'd16; tdm_num = 5'd8; data_delay = 1'b0;
    for (int k = 0; k < 8; k++) begin
      words[k] = 32'h1230 + 32'(k);
      push_exp(32'h1230 + 32'(k), k, k == 7);
    end
    append_frame(16, 8, 1'b0, 128); append_idle(4);
    play(-1);
    drain("t2_drain");

    // Back-pressure: second word dropped
    word_width = 6'd16; tdm_num = 5'd2; data_delay = 1'b0;
    m_tready = 1'b0;
    words[0] = 32'h0000_BEEF; words[1] = 32'h0000_1234;
    push_exp(32'h0000_BEEF, 0, 1'b0);
    append_frame(16, 2, 1'b0, 32); append_idle(4);
    play(-1);
    cycles(4);
    @(negedge mclki);
    chk("t3_hold_valid", 32'(m_tvalid), 32'd1);
    chk("t3_hold_data", m_tdata, 32'h0000_BEEF);
    chk("t3_overflow", 32'(overflow), 32'd1);
    @(posedge mclki); #1;
    m_tready = 1'b1;
    drain("t3_drain");

    // Early sync at bit 10 of slot 1
    words[0] = 32'h0000_1111; words[1] = 32'h0000_2222;
    push_exp(32'h0000_1111, 0, 1'b0);
    append_frame(16, 2, 1'b0, 26);
    words[0] = 32'h0000_3333; words[1] = 32'h0000_4444;
    push_exp(32'h0000_3333, 0, 1'b0);
    push_exp(32'h0000_4444, 1, 1'b1);
    append_frame(16, 2, 1'b0, 32); append_idle(4);
    play(-1);
    drain("t4_drain");
    @(negedge mclki);
    chk("t4_frame_err", 32'(frame_err), 32'd1);

    // Enable dropped mid-word: frame discarded, sticky flags cleared
    words[0] = 32'h0000_5555; words[1] = 32'h0000_6666;
    append_frame(16, 2, 1'b0, 32);
    play(8);
    @(posedge mclki); #1;
    enable = 1'b0;
    cycles(3);
    enable = 1'b1;
    cycles(2);
    @(negedge mclki);
    chk("t5_overflow_clr", 32'(overflow), 32'd0);
    chk("t5_frame_err_clr", 32'(frame_err), 32'd0);
    chk("t5_tvalid_low", 32'(m_tvalid), 32'd0);
    play(-1);
    words[0] = 32'h0000_7777; words[1] = 32'h0000_8888;
    push_exp(32'h0000_7777, 0, 1'b0);
    push_exp(32'h0000_8888, 1, 1'b1);
    append_frame(16, 2, 1'b0, 32); append_idle(4);
    play(-1);
    drain("t5_drain");

    // Two back-to-back 32x4 frames for frame length status
    word_width = 6'd32; tdm_num = 5'd4; data_delay = 1'b0;
    for (int k = 0; k < 4; k++) begin
      words[k] = 32'hC0DE_0000 + 32'(k);
      push_exp(32'hC0DE_0000 + 32'(k), k, k == 3);
    end
    append_frame(32, 4, 1'b0, 128);
    for (int k = 0; k < 4; k++) begin
      words[k] = 32'hF00D_0000 + 32'(k);
      push_exp(32'hF00D_0000 + 32'(k), k, k == 3);
    end
    append_frame(32, 4, 1'b0, 128); append_idle(4);
    play(-1);
    drain("t6_drain");
    @(negedge mclki);
`ifdef I2S_RX_STATUS_EN
    chk("t6_frame_bclks", 32'(frame_bclks), 32'd128);
`else
    chk("t6_frame_bclks", 32'(frame_bclks), 32'd0);
`endif
    chk("t6_frame_err", 32'(frame_err), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
